// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : regfile_pkg                                            |
// | Description : Shared types, constants and address-validity helper    |
// |               for the multi-port register file with scoreboard.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package regfile_pkg;

  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_ADDRESS_WIDTH = 5;

  typedef logic [RF_DATA_WIDTH-1:0]    rf_data_t;
  typedef logic [RF_ADDRESS_WIDTH-1:0] rf_addr_t;

  // Register 0 is the hardwired-zero register when that option is enabled.
  localparam int RF_ZERO_ADDR = 0;

  // An address names a real, writable register: inside the implemented range
  // and not the hardwired zero register. Reads use the same rule to decide
  // whether they see storage or a constant zero. The address is passed
  // zero-extended to 32 bits so the full address width takes part in the test.
  function automatic logic is_valid_wr_addr(input logic [31:0] addr,
                                            input int          num_regs,
                                            input int          zero_reg);
    logic below;
    logic is_zero;
    below   = (addr < 32'(num_regs));
    is_zero = (addr == 32'(RF_ZERO_ADDR));
    return below && !((zero_reg != 0) && is_zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rf_write_arbiter                                       |
// | Description : Combinational write-port arbiter. Turns the packed     |
// |               write ports into per-register enables and data, with   |
// |               the highest-index port winning, and flags collisions.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_WR        = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_dest,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_REGS-1:0]             reg_we,
  output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_wdata,
  output logic                            collision
);

  // Per-port: zero-extended destination, and whether the write really lands.
  logic [31:0]       port_addr [NUM_WR];
  logic [NUM_WR-1:0] port_ok;

  generate
    for (genvar k = 0; k < NUM_WR; k++) begin : g_port
      assign port_addr[k] = 32'(wr_dest[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
      // Out-of-range and zero-register writes are dropped here so they can
      // neither change state nor count as a collision.
      assign port_ok[k]   = wr_en[k] && is_valid_wr_addr(port_addr[k], NUM_REGS, ZERO_REG);
    end
  endgenerate

  // Scan ports in ascending order so a later (higher-index) port overwrites
  // the data chosen by an earlier one; a second hit on a register is a collision.
  always_comb begin
    reg_we    = '0;
    reg_wdata = '0;
    collision = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (port_ok[k] && (port_addr[k] == 32'(r))) begin
          if (reg_we[r]) begin
            collision = 1'b1;
          end
          reg_we[r]                               = 1'b1;
          reg_wdata[r*DATA_WIDTH +: DATA_WIDTH]   = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_mp_sb                                          |
// | Description : Parametrised N-read / M-write register file with       |
// |               optional same-cycle bypass, optional hardwired zero    |
// |               register and a per-register busy scoreboard for RAW    |
// |               hazard detection between decode and writeback.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_dest,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            sb_set_en,
  input  logic [ADDRESS_WIDTH-1:0]        sb_set_dest,
  input  logic                            flush,
  output logic [NUM_REGS-1:0]             busy_vec,
  output logic                            wr_conflict
);

  // Arbitrated per-register write view, shared by storage, bypass and scoreboard.
  logic [NUM_REGS-1:0]            reg_we;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_wdata;
  logic                           collision;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  conflict_q;

  logic [31:0] set_addr;
  logic        set_ok;

  rf_write_arbiter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .NUM_WR        (NUM_WR),
    .ZERO_REG      (ZERO_REG)
  ) u_arb (
    .wr_en     (wr_en),
    .wr_dest   (wr_dest),
    .wr_data   (wr_data),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .collision (collision)
  );

  // Register storage: each register loads its arbitrated write data when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (reg_we[r]) begin
          regs[r] <= reg_wdata[r*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // A set to an unimplemented register or to the zero register is a no-op.
  assign set_addr = 32'(sb_set_dest);
  assign set_ok   = sb_set_en && is_valid_wr_addr(set_addr, NUM_REGS, ZERO_REG);

  // Scoreboard next state: flush beats a new producer, which beats a writeback clear.
  always_comb begin
    busy_next = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush) begin
        busy_next[r] = 1'b0;
      end else if (set_ok && (set_addr == 32'(r))) begin
        busy_next[r] = 1'b1;
      end else if (reg_we[r]) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  // Scoreboard and collision flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_next;
      conflict_q <= collision;
    end
  end

  assign busy_vec    = busy_q;
  assign wr_conflict = conflict_q;

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [31:0]           addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  busy;

      assign addr = 32'(rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]);

      // Read mux: invalid addresses read 0/not-busy; a same-cycle write wins
      // over storage when bypass is built in, and the value then is not busy.
      always_comb begin
        data = '0;
        busy = 1'b0;
        if (is_valid_wr_addr(addr, NUM_REGS, ZERO_REG)) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            if (addr == 32'(r)) begin
              if ((BYPASS != 0) && reg_we[r]) begin
                data = reg_wdata[r*DATA_WIDTH +: DATA_WIDTH];
              end else begin
                data = regs[r];
                busy = busy_q[r];
              end
            end
          end
        end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
      assign rd_busy[p]                          = busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_regfile_mp_sb                                       |
// | Description : Self-checking bench for regfile_mp_sb. Two builds:     |
// |               A = bypass, zero reg, 6-bit addresses over 32 regs;    |
// |               B = no bypass, no zero reg, 5-bit addresses, 24 regs.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  logic [1:0]  a_wr_en;     logic [11:0] a_wr_dest;  logic [63:0] a_wr_data;
  logic [11:0] a_rd_addr;   logic [63:0] a_rd_data;  logic [1:0]  a_rd_busy;
  logic        a_sb_set_en; logic [5:0]  a_sb_set_dest; logic a_flush;
  logic [31:0] a_busy_vec;  logic        a_wr_conflict;

  logic [1:0]  b_wr_en;     logic [9:0]  b_wr_dest;  logic [63:0] b_wr_data;
  logic [9:0]  b_rd_addr;   logic [63:0] b_rd_data;  logic [1:0]  b_rd_busy;
  logic        b_sb_set_en; logic [4:0]  b_sb_set_dest; logic b_flush;
  logic [23:0] b_busy_vec;  logic        b_wr_conflict;

  regfile_mp_sb #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6), .NUM_REGS(32), .NUM_RD(2),
                  .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_dest(a_wr_dest), .wr_data(a_wr_data),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .sb_set_en(a_sb_set_en), .sb_set_dest(a_sb_set_dest), .flush(a_flush),
    .busy_vec(a_busy_vec), .wr_conflict(a_wr_conflict));

  regfile_mp_sb #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_REGS(24), .NUM_RD(2),
                  .NUM_WR(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_dest(b_wr_dest), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .sb_set_en(b_sb_set_en), .sb_set_dest(b_sb_set_dest), .flush(b_flush),
    .busy_vec(b_busy_vec), .wr_conflict(b_wr_conflict));

  int n_vec = 0;
  int n_bad = 0;

  // Current-cycle stimulus, applied to one build at a time.
  bit          s_we [2];
  int          s_wa [2];
  logic [31:0] s_wd [2];
  int          s_ra [2];
  bit          s_set;
  int          s_sdest;
  bit          s_flush;

  // Reference model: configuration and architectural state per build.
  int          nregs [2] = '{32, 24};
  bit          zr    [2] = '{1'b1, 1'b0};
  bit          byp   [2] = '{1'b1, 1'b0};
  logic [31:0] m_mem  [2][64];
  bit          m_busy [2][64];
  bit          m_conf [2];

  typedef struct {
    int d;
    bit we0; int wa0; logic [31:0] wd0;
    bit we1; int wa1; logic [31:0] wd1;
    int ra0; int ra1;
    bit set; int sdest; bit flush;
    logic [31:0] e0; bit b0; logic [31:0] e1; bit b1;
    logic [31:0] bv; bit cf;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(int d, bit we0, int wa0, logic [31:0] wd0,
                              bit we1, int wa1, logic [31:0] wd1, int ra0, int ra1,
                              bit set, int sdest, bit flush,
                              logic [31:0] e0, bit b0, logic [31:0] e1, bit b1,
                              logic [31:0] bv, bit cf);
    vec_t v;
    v.d = d; v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0; v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.set = set; v.sdest = sdest; v.flush = flush;
    v.e0 = e0; v.b0 = b0; v.e1 = e1; v.b1 = b1; v.bv = bv; v.cf = cf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    for (int k = 0; k < 2; k++) begin
      s_we[k] = 1'b0; s_wa[k] = 0; s_wd[k] = '0; s_ra[k] = 0;
    end
    s_set = 1'b0; s_sdest = 0; s_flush = 1'b0;
  endtask

  task automatic drive(input int d);
    a_wr_en = '0; a_wr_dest = '0; a_wr_data = '0; a_rd_addr = '0;
    a_sb_set_en = 1'b0; a_sb_set_dest = '0; a_flush = 1'b0;
    b_wr_en = '0; b_wr_dest = '0; b_wr_data = '0; b_rd_addr = '0;
    b_sb_set_en = 1'b0; b_sb_set_dest = '0; b_flush = 1'b0;
    if (d == 0) begin
      a_wr_en       = {s_we[1], s_we[0]};
      a_wr_dest     = {6'(s_wa[1]), 6'(s_wa[0])};
      a_wr_data     = {s_wd[1], s_wd[0]};
      a_rd_addr     = {6'(s_ra[1]), 6'(s_ra[0])};
      a_sb_set_en   = s_set;
      a_sb_set_dest = 6'(s_sdest);
      a_flush       = s_flush;
    end else begin
      b_wr_en       = {s_we[1], s_we[0]};
      b_wr_dest     = {5'(s_wa[1]), 5'(s_wa[0])};
      b_wr_data     = {s_wd[1], s_wd[0]};
      b_rd_addr     = {5'(s_ra[1]), 5'(s_ra[0])};
      b_sb_set_en   = s_set;
      b_sb_set_dest = 5'(s_sdest);
      b_flush       = s_flush;
    end
  endtask

  task automatic get_rd(input int d, input int p, output logic [31:0] data, output logic busy);
    if (d == 0) begin
      data = a_rd_data[p*32 +: 32]; busy = a_rd_busy[p];
    end else begin
      data = b_rd_data[p*32 +: 32]; busy = b_rd_busy[p];
    end
  endtask

  function automatic logic [31:0] act_bv(input int d);
    return (d == 0) ? a_busy_vec : {8'h00, b_busy_vec};
  endfunction

  function automatic logic act_cf(input int d);
    return (d == 0) ? a_wr_conflict : b_wr_conflict;
  endfunction

  function automatic bit addr_ok(input int d, input int a);
    return (a >= 0) && (a < nregs[d]) && !(zr[d] && (a == 0));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_conf[d] = 1'b0;
      for (int r = 0; r < 64; r++) begin
        m_mem[d][r] = '0; m_busy[d][r] = 1'b0;
      end
    end
  endtask

  // What a read of address a shows this cycle, given the current stimulus.
  task automatic exp_read(input int d, input int a, output logic [31:0] data, output logic busy);
    data = '0; busy = 1'b0;
    if (addr_ok(d, a)) begin
      data = m_mem[d][a]; busy = m_busy[d][a];
      if (byp[d]) begin
        for (int k = 0; k < 2; k++) begin
          if (s_we[k] && addr_ok(d, s_wa[k]) && (s_wa[k] == a)) begin
            data = s_wd[k]; busy = 1'b0;
          end
        end
      end
    end
  endtask

  // Clock-edge update of the model from the current stimulus.
  task automatic model_step(input int d);
    int hits [64];
    for (int r = 0; r < 64; r++) hits[r] = 0;
    m_conf[d] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (s_we[k] && addr_ok(d, s_wa[k])) begin
        hits[s_wa[k]]++;
        m_mem[d][s_wa[k]] = s_wd[k];
      end
    end
    for (int r = 0; r < 64; r++) begin
      if (hits[r] > 1) m_conf[d] = 1'b1;
      if (s_flush) m_busy[d][r] = 1'b0;
      else if (s_set && addr_ok(d, s_sdest) && (s_sdest == r)) m_busy[d][r] = 1'b1;
      else if (hits[r] > 0) m_busy[d][r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_bv(input int d);
    logic [31:0] v = '0;
    for (int r = 0; r < nregs[d]; r++) v[r] = m_busy[d][r];
    return v;
  endfunction

  task automatic model_cycle(input int d, input string tag);
    logic [31:0] ad, ed;
    logic        ab, eb;
    drive(d);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_read(d, s_ra[p], ed, eb);
      get_rd(d, p, ad, ab);
      chk($sformatf("%s_rd%0d_data", tag, p), 64'(ad), 64'(ed));
      chk($sformatf("%s_rd%0d_busy", tag, p), 64'(ab), 64'(eb));
    end
    @(posedge clk);
    #1;
    model_step(d);
    chk($sformatf("%s_busy_vec", tag), 64'(act_bv(d)), 64'(exp_bv(d)));
    chk($sformatf("%s_conflict", tag), 64'(act_cf(d)), 64'(m_conf[d]));
  endtask

  function automatic int pick(input int amax);
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, amax));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [31:0] ad;
    logic        ab;

    // Build A rows: bypass, zero register, out-of-range address 40.
    tbl.push_back(mk(0, 1,5,32'hDEADBEEF, 0,0,0, 5,0, 0,0,0, 32'hDEADBEEF,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,5, 0,0,0, 0,0, 32'hDEADBEEF,0, 32'h0,0));
    tbl.push_back(mk(0, 1,7,32'h11, 1,7,32'h22, 7,5, 0,0,0, 32'h22,0, 32'hDEADBEEF,0, 32'h0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 7,0, 0,0,0, 32'h22,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 1,0,32'hFFFFFFFF, 1,40,32'h12345678, 0,40, 0,0,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,40, 0,0,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 3,0, 1,3,0, 0,0, 0,0, 32'h8,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 3,7, 0,0,0, 0,1, 32'h22,0, 32'h8,0));
    tbl.push_back(mk(0, 0,0,0, 1,3,32'h5, 3,0, 0,0,0, 32'h5,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 1,9,32'h99, 0,0,0, 9,3, 1,9,0, 32'h99,0, 32'h5,0, 32'h200,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 9,0, 0,0,0, 32'h99,1, 0,0, 32'h200,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 4,0, 1,4,0, 0,0, 0,0, 32'h210,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 9,4, 1,4,1, 32'h99,1, 0,1, 32'h0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 1,0,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 40,40, 1,40,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 1,0,32'hAAAA, 1,0,32'hBBBB, 0,0, 0,0,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(0, 1,31,32'h1111, 1,31,32'h2222, 31,7, 0,0,0, 32'h2222,0, 32'h22,0, 32'h0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 31,0, 0,0,0, 32'h2222,0, 0,0, 32'h0,0));
    // Build B rows: no bypass, writable r0, 24 registers.
    tbl.push_back(mk(1, 1,6,32'hA, 0,0,0, 6,0, 0,0,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 6,0, 0,0,0, 32'hA,0, 0,0, 32'h0,0));
    tbl.push_back(mk(1, 1,0,32'h77, 1,30,32'h55, 0,30, 0,0,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,30, 0,0,0, 32'h77,0, 0,0, 32'h0,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 1,0,0, 32'h77,0, 32'h77,0, 32'h1,0));
    tbl.push_back(mk(1, 1,0,32'h1, 1,0,32'h2, 0,0, 1,0,0, 32'h77,1, 32'h77,1, 32'h1,1));
    tbl.push_back(mk(1, 1,0,32'h3, 0,0,0, 0,0, 0,0,0, 32'h2,1, 32'h2,1, 32'h0,0));
    tbl.push_back(mk(1, 1,23,32'h9, 0,0,0, 23,24, 1,24,0, 0,0, 0,0, 32'h0,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 23,24, 0,0,0, 32'h9,0, 0,0, 32'h0,0));

    // Reset state, held from time 0.
    model_reset();
    set_idle();
    s_ra[0] = 5; s_ra[1] = 3;
    drive(0);
    #2;
    chk("reset_rd0", 64'(a_rd_data), 64'h0);
    chk("reset_busy_vec_a", 64'(a_busy_vec), 64'h0);
    chk("reset_conflict_a", 64'(a_wr_conflict), 64'h0);
    chk("reset_busy_vec_b", 64'(b_busy_vec), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      s_we[0] = tbl[i].we0; s_wa[0] = tbl[i].wa0; s_wd[0] = tbl[i].wd0;
      s_we[1] = tbl[i].we1; s_wa[1] = tbl[i].wa1; s_wd[1] = tbl[i].wd1;
      s_ra[0] = tbl[i].ra0; s_ra[1] = tbl[i].ra1;
      s_set = tbl[i].set; s_sdest = tbl[i].sdest; s_flush = tbl[i].flush;
      drive(tbl[i].d);
      #1;
      get_rd(tbl[i].d, 0, ad, ab);
      chk($sformatf("tbl%0d_rd0_data", i), 64'(ad), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_rd0_busy", i), 64'(ab), 64'(tbl[i].b0));
      get_rd(tbl[i].d, 1, ad, ab);
      chk($sformatf("tbl%0d_rd1_data", i), 64'(ad), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_rd1_busy", i), 64'(ab), 64'(tbl[i].b1));
      @(posedge clk);
      #1;
      model_step(tbl[i].d);
      chk($sformatf("tbl%0d_busy_vec", i), 64'(act_bv(tbl[i].d)), 64'(tbl[i].bv));
      chk($sformatf("tbl%0d_conflict", i), 64'(act_cf(tbl[i].d)), 64'(tbl[i].cf));
    end

    // Asynchronous reset in mid-cycle: state clears without a clock edge,
    // and a write pending across the reset edge is lost.
    set_idle(); s_set = 1'b1; s_sdest = 2;
    model_cycle(0, "prerst_a");
    model_cycle(1, "prerst_b");
    set_idle();
    s_we[0] = 1'b1; s_wa[0] = 8; s_wd[0] = 32'hCAFE; s_ra[0] = 2; s_ra[1] = 5;
    drive(0);
    #2;
    chk("prerst_rd1", 64'(a_rd_data[63:32]), 64'hDEADBEEF);
    chk("prerst_busy_vec", 64'(a_busy_vec), 64'h4);
    rst = 1'b0;
    #1;
    chk("midrst_rd1", 64'(a_rd_data[63:32]), 64'h0);
    chk("midrst_rd0_busy", 64'(a_rd_busy[0]), 64'h0);
    chk("midrst_busy_vec_a", 64'(a_busy_vec), 64'h0);
    chk("midrst_busy_vec_b", 64'(b_busy_vec), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    set_idle(); s_ra[0] = 8; s_ra[1] = 5;
    model_cycle(0, "postrst");

    // Randomized traffic on both builds against the model.
    for (int i = 0; i < 400; i++) begin
      int d;
      int amax;
      d    = int'($urandom_range(0, 1));
      amax = (d == 0) ? 63 : 31;
      for (int k = 0; k < 2; k++) begin
        s_we[k] = bit'($urandom_range(0, 1));
        s_wa[k] = pick(amax);
        s_wd[k] = $urandom;
        s_ra[k] = pick(amax);
      end
      s_set   = ($urandom_range(0, 2) == 0);
      s_sdest = pick(amax);
      s_flush = ($urandom_range(0, 15) == 0);
      model_cycle(d, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
